dimm_cmd_responder: RTL and testbench

DIMM_CMD_RESPONDER -- requirements
Module: dimm_cmd_responder

---
 rtl/dimm_cmd_responder.sv | 279 +++++++++++++++++++++++++++
 tb/tb_dimm_cmd_responder.sv | 406 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dimm_cmd_responder.sv
// DIMM command responder: per-bank open/close tracking for a two-cycle
// command stream, with read/write beat scheduling on one shared data bus.
module dimm_cmd_responder #(
  parameter int TRCD   = 4,
  parameter int TRP    = 4,
  parameter int TCL    = 6,
  parameter int TCWL   = 4,
  parameter int TBURST = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  input  logic [2:0]  cmd_op,
  input  logic [2:0]  cmd_bg,
  input  logic [1:0]  cmd_ba,
  input  logic [15:0] cmd_row,
  input  logic [5:0]  cmd_col,
  output logic        rd_valid,
  output logic        wr_ready,
  output logic [5:0]  data_col,
  output logic [31:0] bank_active,
  output logic        err_pulse,
  output logic [2:0]  err_code
);

  localparam int TMAX = (TRCD > TRP) ? TRCD : TRP;
  localparam int TW   = $clog2(TMAX + 1);
  localparam int LMAX = (TCL > TCWL) ? TCL : TCWL;
  localparam int W    = LMAX + TBURST - 1;

  localparam logic [2:0] OP_NOP  = 3'd0;
  localparam logic [2:0] OP_ACT0 = 3'd1;
  localparam logic [2:0] OP_ACT1 = 3'd2;
  localparam logic [2:0] OP_RD0  = 3'd3;
  localparam logic [2:0] OP_RD1  = 3'd4;
  localparam logic [2:0] OP_WR0  = 3'd5;
  localparam logic [2:0] OP_WR1  = 3'd6;
  localparam logic [2:0] OP_PRE  = 3'd7;

  localparam logic [2:0] E_NONE = 3'd0;
  localparam logic [2:0] E_SEQ  = 3'd1;
  localparam logic [2:0] E_ACT  = 3'd2;
  localparam logic [2:0] E_NACT = 3'd3;
  localparam logic [2:0] E_PRE  = 3'd4;
  localparam logic [2:0] E_BUS  = 3'd5;

  typedef enum logic [1:0] {
    B_IDLE,
    B_OPENING,
    B_ACTIVE,
    B_CLOSING
  } bank_e;

  bank_e           bstate [32];
  logic [TW-1:0]   btimer [32];
  logic [15:0]     brow   [32];

  logic            pend_valid;
  logic            pend_bad;
  logic [2:0]      pend_op;
  logic [4:0]      pend_bank;
  logic [15:0]     pend_row;
  logic [5:0]      pend_col;

  // slot[k] holds the bus beat driven one edge after k+1 further edges
  logic [W-1:0]    slot_occ;
  logic [W-1:0]    slot_rd;
  logic [5:0]      slot_col [W];

  logic [2:0]      op;
  logic [4:0]      bank;
  bank_e           cur_state;
  logic            op_first;
  logic            op_second;
  logic            op_pre;
  logic            second_ok;
  logic            rd_clash;
  logic            wr_clash;

  logic [2:0]      err_next;
  logic            take_pend;
  logic            pend_bad_d;
  logic            fire_act;
  logic            fire_rd;
  logic            fire_wr;
  logic            fire_pre;

  assign op        = cmd_valid ? cmd_op : OP_NOP;
  assign bank      = {cmd_bg, cmd_ba};
  assign cur_state = bstate[bank];

  assign op_first  = (op == OP_ACT0) ||
                     (op == OP_RD0)  ||
                     (op == OP_WR0);
  assign op_second = (op == OP_ACT1) ||
                     (op == OP_RD1)  ||
                     (op == OP_WR1);
  assign op_pre    = (op == OP_PRE);

  assign second_ok = (op == pend_op + 3'd1) &&
                     (bank == pend_bank) &&
                     (cmd_row == pend_row) &&
                     (cmd_col == pend_col);

  always_comb begin
    bank_active = '0;
    for (int i = 0; i < 32; i++) begin
      bank_active[i] = (bstate[i] == B_ACTIVE);
    end
  end

  // Bus clash: compare the new burst window against the schedule
  // as it will look after this edge's shift.
  always_comb begin
    rd_clash = 1'b0;
    wr_clash = 1'b0;
    for (int k = 0; k < W; k++) begin
      if (slot_occ[k] &&
          k >= TCL - 1 &&
          k <= TCL + TBURST - 2)
        rd_clash = 1'b1;
      if (slot_occ[k] &&
          k >= TCWL - 1 &&
          k <= TCWL + TBURST - 2)
        wr_clash = 1'b1;
    end
  end

  always_comb begin
    err_next   = E_NONE;
    take_pend  = 1'b0;
    pend_bad_d = 1'b0;
    fire_act   = 1'b0;
    fire_rd    = 1'b0;
    fire_wr    = 1'b0;
    fire_pre   = 1'b0;
    unique case (1'b1)
      pend_valid && !second_ok: begin
        err_next = E_SEQ;
      end
      pend_valid && second_ok && !pend_bad: begin
        unique case (pend_op)
          OP_ACT0: fire_act = 1'b1;
          OP_RD0: begin
            if (rd_clash) err_next = E_BUS;
            else          fire_rd  = 1'b1;
          end
          OP_WR0: begin
            if (wr_clash) err_next = E_BUS;
            else          fire_wr  = 1'b1;
          end
          default: ;
        endcase
      end
      !pend_valid && op_first: begin
        take_pend = 1'b1;
        if (op == OP_ACT0) begin
          if (cur_state != B_IDLE) begin
            pend_bad_d = 1'b1;
            err_next   = E_ACT;
          end
        end else if (cur_state != B_ACTIVE) begin
          pend_bad_d = 1'b1;
          err_next   = E_NACT;
        end
      end
      !pend_valid && op_second: begin
        err_next = E_SEQ;
      end
      !pend_valid && op_pre: begin
        if (cur_state == B_ACTIVE)
          fire_pre = 1'b1;
        else if (cur_state != B_IDLE)
          err_next = E_PRE;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        bstate[i] <= B_IDLE;
        btimer[i] <= '0;
        brow[i]   <= '0;
      end
      pend_valid <= 1'b0;
      pend_bad   <= 1'b0;
      pend_op    <= OP_NOP;
      pend_bank  <= '0;
      pend_row   <= '0;
      pend_col   <= '0;
      slot_occ   <= '0;
      slot_rd    <= '0;
      for (int k = 0; k < W; k++) begin
        slot_col[k] <= '0;
      end
      rd_valid  <= 1'b0;
      wr_ready  <= 1'b0;
      data_col  <= '0;
      err_pulse <= 1'b0;
      err_code  <= E_NONE;
    end else begin
      // Timers: a bank flips one edge early so that a first half
      // arriving TRCD/TRP edges after the command sees the new state.
      for (int i = 0; i < 32; i++) begin
        unique case (bstate[i])
          B_OPENING: begin
            if (btimer[i] <= TW'(1)) begin
              bstate[i] <= B_ACTIVE;
              btimer[i] <= '0;
            end else begin
              btimer[i] <= btimer[i] - 1'b1;
            end
          end
          B_CLOSING: begin
            if (btimer[i] <= TW'(1)) begin
              bstate[i] <= B_IDLE;
              btimer[i] <= '0;
            end else begin
              btimer[i] <= btimer[i] - 1'b1;
            end
          end
          default: ;
        endcase
        brow[i] <= (bstate[i] == B_IDLE) ? '0 : brow[i];
      end

      if (fire_act) begin
        bstate[pend_bank] <= (TRCD <= 1) ? B_ACTIVE : B_OPENING;
        btimer[pend_bank] <= TW'(TRCD - 1);
        brow[pend_bank]   <= pend_row;
      end
      if (fire_pre) begin
        bstate[bank] <= (TRP <= 1) ? B_IDLE : B_CLOSING;
        btimer[bank] <= TW'(TRP - 1);
      end

      pend_valid <= take_pend;
      if (take_pend) begin
        pend_bad  <= pend_bad_d;
        pend_op   <= op;
        pend_bank <= bank;
        pend_row  <= cmd_row;
        pend_col  <= cmd_col;
      end

      slot_occ <= slot_occ >> 1;
      slot_rd  <= slot_rd >> 1;
      for (int k = 0; k < W - 1; k++) begin
        slot_col[k] <= slot_col[k + 1];
      end
      slot_col[W-1] <= '0;
      if (fire_rd) begin
        for (int j = 0; j < TBURST; j++) begin
          slot_occ[TCL - 2 + j] <= 1'b1;
          slot_rd[TCL - 2 + j]  <= 1'b1;
          slot_col[TCL - 2 + j] <= pend_col;
        end
      end
      if (fire_wr) begin
        for (int j = 0; j < TBURST; j++) begin
          slot_occ[TCWL - 2 + j] <= 1'b1;
          slot_rd[TCWL - 2 + j]  <= 1'b0;
          slot_col[TCWL - 2 + j] <= pend_col;
        end
      end

      rd_valid <= slot_occ[0] & slot_rd[0];
      wr_ready <= slot_occ[0] & ~slot_rd[0];
      data_col <= slot_occ[0] ? slot_col[0] : '0;

      err_pulse <= (err_next != E_NONE);
      if (err_next != E_NONE)
        err_code <= err_next;
    end
  end

endmodule

// File: tb/tb_dimm_cmd_responder.sv
// Directed bench for dimm_cmd_responder; inputs change on the falling edge,
// so outputs read there are the values seen by the next rising edge.
module tb_dimm_cmd_responder;

  localparam logic [2:0] NOP  = 3'd0;
  localparam logic [2:0] ACT0 = 3'd1;
  localparam logic [2:0] ACT1 = 3'd2;
  localparam logic [2:0] RD0  = 3'd3;
  localparam logic [2:0] RD1  = 3'd4;
  localparam logic [2:0] WR0  = 3'd5;
  localparam logic [2:0] WR1  = 3'd6;
  localparam logic [2:0] PRE  = 3'd7;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_op = '0;
  logic [2:0]  cmd_bg = '0;
  logic [1:0]  cmd_ba = '0;
  logic [15:0] cmd_row = '0;
  logic [5:0]  cmd_col = '0;
  logic        rd_valid;
  logic        wr_ready;
  logic [5:0]  data_col;
  logic [31:0] bank_active;
  logic        err_pulse;
  logic [2:0]  err_code;

  int n_cmp = 0;
  int n_bad = 0;

  dimm_cmd_responder dut (
    .clk(clk),
    .rst_n(rst_n),
    .cmd_valid(cmd_valid),
    .cmd_op(cmd_op),
    .cmd_bg(cmd_bg),
    .cmd_ba(cmd_ba),
    .cmd_row(cmd_row),
    .cmd_col(cmd_col),
    .rd_valid(rd_valid),
    .wr_ready(wr_ready),
    .data_col(data_col),
    .bank_active(bank_active),
    .err_pulse(err_pulse),
    .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic tick(input logic [2:0] op, input logic [2:0] bg,
                      input logic [1:0] ba, input logic [15:0] row,
                      input logic [5:0] col);
    @(negedge clk);
    cmd_valid = (op != NOP);
    cmd_op    = op;
    cmd_bg    = bg;
    cmd_ba    = ba;
    cmd_row   = row;
    cmd_col   = col;
  endtask

  task automatic do_reset;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_op    = NOP;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    cmd_valid = 1'b1;
    cmd_op    = ACT0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_rd got=%b want=0", rd_valid);
    end
    n_cmp++;
    if (wr_ready !== 1'b0) begin
      n_bad++; $display("FAIL reset_wr got=%b want=0", wr_ready);
    end
    n_cmp++;
    if (data_col !== 6'd0) begin
      n_bad++; $display("FAIL reset_col got=%0d want=0", data_col);
    end
    n_cmp++;
    if (bank_active !== 32'd0) begin
      n_bad++; $display("FAIL reset_bank got=%h want=0", bank_active);
    end
    n_cmp++;
    if (err_pulse !== 1'b0) begin
      n_bad++; $display("FAIL reset_errp got=%b want=0", err_pulse);
    end
    n_cmp++;
    if (err_code !== 3'd0) begin
      n_bad++; $display("FAIL reset_code got=%0d want=0", err_code);
    end
    cmd_valid = 1'b0;
    cmd_op    = NOP;
    rst_n     = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bank_active !== 32'd0 || err_code !== 3'd0) begin
      n_bad++;
      $display("FAIL reset_idle bank=%h code=%0d want 0/0", bank_active, err_code);
    end
  endtask

  task automatic test_read;
    logic [2:0] op;
    logic       exp_rd;
    do_reset;
    for (int e = -1; e <= 16; e++) begin
      op = NOP;
      case (e)
        -1: op = ACT0;
        0:  op = ACT1;
        4:  op = RD0;
        5:  op = RD1;
        default: ;
      endcase
      tick(op, 3'd2, 2'd1, 16'h1234, 6'd5);
      exp_rd = (e >= 11 && e <= 14);
      n_cmp++;
      if (rd_valid !== exp_rd) begin
        n_bad++; $display("FAIL read_rd e=%0d got=%b want=%b", e, rd_valid, exp_rd);
      end
      n_cmp++;
      if (bank_active[9] !== (e >= 4)) begin
        n_bad++; $display("FAIL read_bank e=%0d got=%b want=%b", e, bank_active[9], e >= 4);
      end
      n_cmp++;
      if (err_pulse !== 1'b0) begin
        n_bad++; $display("FAIL read_err e=%0d got=%b want=0", e, err_pulse);
      end
      if (exp_rd) begin
        n_cmp++;
        if (data_col !== 6'd5) begin
          n_bad++; $display("FAIL read_col e=%0d got=%0d want=5", e, data_col);
        end
      end
    end
  endtask

  task automatic test_trcd;
    logic [2:0] op;
    logic [2:0] exp_code;
    do_reset;
    for (int e = -1; e <= 16; e++) begin
      op = NOP;
      case (e)
        -1: op = ACT0;
        0:  op = ACT1;
        2:  op = RD0;
        3:  op = RD1;
        default: ;
      endcase
      tick(op, 3'd1, 2'd0, 16'h00ab, 6'd2);
      exp_code = (e >= 3) ? 3'd3 : 3'd0;
      n_cmp++;
      if (err_pulse !== (e == 3)) begin
        n_bad++; $display("FAIL trcd_errp e=%0d got=%b want=%b", e, err_pulse, e == 3);
      end
      n_cmp++;
      if (err_code !== exp_code) begin
        n_bad++; $display("FAIL trcd_code e=%0d got=%0d want=%0d", e, err_code, exp_code);
      end
      n_cmp++;
      if (rd_valid !== 1'b0) begin
        n_bad++; $display("FAIL trcd_rd e=%0d got=%b want=0", e, rd_valid);
      end
    end
  endtask

  task automatic test_seq;
    logic [2:0] op;
    logic [2:0] exp_code;
    logic       exp_p;
    do_reset;
    for (int e = 0; e <= 11; e++) begin
      op = NOP;
      case (e)
        0: op = ACT0;
        4: op = RD0;
        5: op = RD1;
        8: op = WR1;
        default: ;
      endcase
      tick(op, 3'd3, 2'd2, 16'h0042, 6'd1);
      exp_p    = (e == 2 || e == 5 || e == 9);
      exp_code = (e < 2) ? 3'd0 : (e < 5) ? 3'd1 : (e < 9) ? 3'd3 : 3'd1;
      n_cmp++;
      if (err_pulse !== exp_p) begin
        n_bad++; $display("FAIL seq_errp e=%0d got=%b want=%b", e, err_pulse, exp_p);
      end
      n_cmp++;
      if (err_code !== exp_code) begin
        n_bad++; $display("FAIL seq_code e=%0d got=%0d want=%0d", e, err_code, exp_code);
      end
      n_cmp++;
      if (bank_active !== 32'd0) begin
        n_bad++; $display("FAIL seq_bank e=%0d got=%h want=0", e, bank_active);
      end
    end
  endtask

  task automatic test_bus;
    logic [2:0] op;
    logic [1:0] ba;
    logic [5:0] col;
    logic       exp_rd;
    logic [5:0] exp_col;
    do_reset;
    for (int e = 0; e <= 38; e++) begin
      op  = NOP;
      ba  = 2'd1;
      col = 6'd3;
      case (e)
        0:  op = ACT0;
        1:  op = ACT1;
        2:  begin op = ACT0; ba = 2'd2; col = 6'd7; end
        3:  begin op = ACT1; ba = 2'd2; col = 6'd7; end
        8:  op = RD0;
        9:  op = RD1;
        10: begin op = RD0; ba = 2'd2; col = 6'd7; end
        11: begin op = RD1; ba = 2'd2; col = 6'd7; end
        20: op = RD0;
        21: op = RD1;
        24: begin op = RD0; ba = 2'd2; col = 6'd7; end
        25: begin op = RD1; ba = 2'd2; col = 6'd7; end
        default: ;
      endcase
      tick(op, 3'd2, ba, 16'h0777, col);
      exp_rd  = (e >= 15 && e <= 18) || (e >= 27 && e <= 34);
      exp_col = (e <= 30) ? 6'd3 : 6'd7;
      n_cmp++;
      if (rd_valid !== exp_rd) begin
        n_bad++; $display("FAIL bus_rd e=%0d got=%b want=%b", e, rd_valid, exp_rd);
      end
      n_cmp++;
      if (err_pulse !== (e == 12)) begin
        n_bad++; $display("FAIL bus_errp e=%0d got=%b want=%b", e, err_pulse, e == 12);
      end
      if (e == 12) begin
        n_cmp++;
        if (err_code !== 3'd5) begin
          n_bad++; $display("FAIL bus_code e=%0d got=%0d want=5", e, err_code);
        end
      end
      if (exp_rd) begin
        n_cmp++;
        if (data_col !== exp_col) begin
          n_bad++; $display("FAIL bus_col e=%0d got=%0d want=%0d", e, data_col, exp_col);
        end
      end
    end
  endtask

  task automatic test_pre;
    logic [2:0] op;
    logic [1:0] ba;
    logic       exp_a;
    logic       exp_p;
    logic [2:0] exp_code;
    do_reset;
    for (int e = 0; e <= 17; e++) begin
      op = NOP;
      ba = 2'd0;
      case (e)
        0, 8, 10: op = ACT0;
        1, 9, 11: op = ACT1;
        6, 12:    op = PRE;
        default: ;
      endcase
      tick(op, (e == 14) ? 3'd0 : 3'd1, ba, 16'h0100, 6'd0);
      if (e == 14) begin
        cmd_valid = 1'b1;
        cmd_op    = PRE;
      end
      exp_a    = (e == 5 || e == 6 || e >= 15);
      exp_p    = (e == 9 || e == 13);
      exp_code = (e < 9) ? 3'd0 : (e < 13) ? 3'd2 : 3'd4;
      n_cmp++;
      if (bank_active[4] !== exp_a) begin
        n_bad++; $display("FAIL pre_bank e=%0d got=%b want=%b", e, bank_active[4], exp_a);
      end
      n_cmp++;
      if (err_pulse !== exp_p) begin
        n_bad++; $display("FAIL pre_errp e=%0d got=%b want=%b", e, err_pulse, exp_p);
      end
      n_cmp++;
      if (err_code !== exp_code) begin
        n_bad++; $display("FAIL pre_code e=%0d got=%0d want=%0d", e, err_code, exp_code);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [2:0] op;
    logic [5:0] col;
    logic       exp_w;
    logic       exp_r;
    do_reset;
    for (int e = 0; e <= 20; e++) begin
      op  = NOP;
      col = 6'd9;
      case (e)
        0:  op = ACT0;
        1:  op = ACT1;
        6:  op = WR0;
        7:  op = WR1;
        8:  begin op = RD0; col = 6'd10; end
        9:  begin op = RD1; col = 6'd10; end
        10: op = PRE;
        default: ;
      endcase
      tick(op, 3'd5, 2'd0, 16'h0abc, col);
      exp_w = (e >= 11 && e <= 14);
      exp_r = (e >= 15 && e <= 18);
      n_cmp++;
      if (wr_ready !== exp_w) begin
        n_bad++; $display("FAIL b2b_wr e=%0d got=%b want=%b", e, wr_ready, exp_w);
      end
      n_cmp++;
      if (rd_valid !== exp_r) begin
        n_bad++; $display("FAIL b2b_rd e=%0d got=%b want=%b", e, rd_valid, exp_r);
      end
      n_cmp++;
      if (err_pulse !== 1'b0) begin
        n_bad++; $display("FAIL b2b_err e=%0d got=%b want=0", e, err_pulse);
      end
      n_cmp++;
      if (bank_active[20] !== (e >= 5 && e <= 10)) begin
        n_bad++;
        $display("FAIL b2b_bank e=%0d got=%b want=%b", e, bank_active[20], e >= 5 && e <= 10);
      end
      if (exp_w || exp_r) begin
        n_cmp++;
        if (data_col !== (exp_w ? 6'd9 : 6'd10)) begin
          n_bad++;
          $display("FAIL b2b_col e=%0d got=%0d want=%0d", e, data_col, exp_w ? 9 : 10);
        end
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [2:0] op;
    do_reset;
    for (int e = 0; e <= 13; e++) begin
      op = NOP;
      case (e)
        0: op = ACT0;
        1: op = ACT1;
        5: op = RD0;
        6: op = RD1;
        default: ;
      endcase
      tick(op, 3'd2, 2'd1, 16'h1234, 6'd5);
      if (e == 12 || e == 13) begin
        n_cmp++;
        if (rd_valid !== 1'b1) begin
          n_bad++; $display("FAIL mid_beat e=%0d got=%b want=1", e, rd_valid);
        end
      end
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (rd_valid !== 1'b0) begin
      n_bad++; $display("FAIL mid_rd_drop got=%b want=0", rd_valid);
    end
    n_cmp++;
    if (bank_active !== 32'd0) begin
      n_bad++; $display("FAIL mid_bank_drop got=%h want=0", bank_active);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if (rd_valid !== 1'b0 || wr_ready !== 1'b0 || bank_active !== 32'd0) begin
        n_bad++;
        $display("FAIL mid_after c=%0d rd=%b wr=%b bank=%h want 0/0/0",
                 c, rd_valid, wr_ready, bank_active);
      end
    end
  endtask

  initial begin
    test_reset;
    test_read;
    test_trcd;
    test_seq;
    test_bus;
    test_pre;
    test_back_to_back;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
